// File: rtl/mux_bus_arbiter_if.sv
// Bus bundle between the two requesters and the shared 2:1 mux arbiter.
// The arbiter connects through the slave modport, the requester side through master.
interface mux_bus_arbiter_if #(
    parameter int BLOCKS = 4,
    parameter int HOLD_W = 4
);
    logic              req_a;
    logic              req_b;
    logic [BLOCKS-1:0] A;
    logic [BLOCKS-1:0] B;
    logic              gnt_a;
    logic              gnt_b;
    logic              Select;
    logic              Enable_bar;
    logic [HOLD_W-1:0] hold_count;
    logic [BLOCKS-1:0] Y_mon;

    modport master (
        output req_a, req_b, A, B,
        input  gnt_a, gnt_b, Select, Enable_bar, hold_count, Y_mon
    );

    modport slave (
        input  req_a, req_b, A, B,
        output gnt_a, gnt_b, Select, Enable_bar, hold_count, Y_mon
    );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Arbiter for one shared 74157-style 2:1 mux between requesters A and B.
// Round-robin on ties, optional hold-time preemption, and a dead window with
// the mux disabled between owners so the two sources never overlap.
module mux_bus_arbiter #(
    parameter int BLOCKS      = 4,
    parameter int HOLD_MAX    = 8,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_W      = $clog2(HOLD_MAX + 2)
) (
    input  logic              clk,
    input  logic              reset_bar,
    mux_bus_arbiter_if.slave  bus
);
    localparam int  TC_W     = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam bit  PREEMPT  = (HOLD_MAX != 0);
    // With preemption off the limit is never used; keep it a legal non-zero value.
    localparam int  HOLD_LIM = PREEMPT ? HOLD_MAX : 1;
    localparam int  HOLD_SAT = HOLD_MAX + 1;

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, TURN} state_t;

    state_t            state_q, state_n;
    logic              gnt_a_q, gnt_a_n;
    logic              gnt_b_q, gnt_b_n;
    logic              sel_q, sel_n;
    logic              enb_q, enb_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic              last_b_q, last_b_n;   // 1: B owned the bus last
    logic [TC_W-1:0]   turn_q, turn_n;       // TURN cycles still to go after this one

    logic              do_arb, go_turn;
    logic              pick_a, pick_b;
    logic              hold_done;

    // Registered state and outputs; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state_q  <= IDLE;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            sel_q    <= 1'b0;
            enb_q    <= 1'b1;
            hold_q   <= '0;
            last_b_q <= 1'b1;
            turn_q   <= '0;
        end else begin
            state_q  <= state_n;
            gnt_a_q  <= gnt_a_n;
            gnt_b_q  <= gnt_b_n;
            sel_q    <= sel_n;
            enb_q    <= enb_n;
            hold_q   <= hold_n;
            last_b_q <= last_b_n;
            turn_q   <= turn_n;
        end
    end

    // Next state: hold/release the current owner, then arbitrate when free.
    always_comb begin
        state_n  = state_q;
        gnt_a_n  = gnt_a_q;
        gnt_b_n  = gnt_b_q;
        sel_n    = sel_q;
        enb_n    = enb_q;
        hold_n   = hold_q;
        last_b_n = last_b_q;
        turn_n   = turn_q;
        go_turn  = 1'b0;

        hold_done = PREEMPT && (hold_q >= HOLD_W'(HOLD_LIM));
        // Tie goes to whoever did not own the bus last.
        pick_a = bus.req_a && (!bus.req_b || last_b_q);
        pick_b = bus.req_b && (!bus.req_a || !last_b_q);
        do_arb = (state_q == IDLE) || ((state_q == TURN) && (turn_q == '0));

        case (state_q)
            GNT_A: begin
                if (!bus.req_a || (hold_done && bus.req_b))
                    go_turn = 1'b1;
                else if (hold_q != HOLD_W'(HOLD_SAT))
                    hold_n = hold_q + 1'b1;
            end
            GNT_B: begin
                if (!bus.req_b || (hold_done && bus.req_a))
                    go_turn = 1'b1;
                else if (hold_q != HOLD_W'(HOLD_SAT))
                    hold_n = hold_q + 1'b1;
            end
            TURN: begin
                if (turn_q != '0)
                    turn_n = turn_q - 1'b1;
            end
            default: ;
        endcase

        // Select is left alone here so it only moves while the mux is disabled.
        if (go_turn) begin
            state_n = TURN;
            gnt_a_n = 1'b0;
            gnt_b_n = 1'b0;
            enb_n   = 1'b1;
            hold_n  = '0;
            turn_n  = TC_W'(TURN_CYCLES - 1);
        end

        if (do_arb) begin
            if (pick_a) begin
                state_n  = GNT_A;
                gnt_a_n  = 1'b1;
                gnt_b_n  = 1'b0;
                sel_n    = 1'b0;
                enb_n    = 1'b0;
                hold_n   = HOLD_W'(1);
                last_b_n = 1'b0;
            end else if (pick_b) begin
                state_n  = GNT_B;
                gnt_a_n  = 1'b0;
                gnt_b_n  = 1'b1;
                sel_n    = 1'b1;
                enb_n    = 1'b0;
                hold_n   = HOLD_W'(1);
                last_b_n = 1'b1;
            end else begin
                state_n  = IDLE;
            end
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.Select     = sel_q;
    assign bus.Enable_bar = enb_q;
    assign bus.hold_count = hold_q;
    assign bus.Y_mon      = enb_q ? '0 : (sel_q ? bus.B : bus.A);
endmodule
